// File: rtl/lock_pkg.sv
// rtl/lock_pkg.sv - shared widths and password-programmer state codes for the lock
package lock_pkg;

   localparam int PW_W    = 7;
   localparam int NUM_SEG = 3;

   // Encodings double as the LED stage code, so they must stay fixed.
   typedef enum logic [3:0] {
      ST_IDLE   = 4'd0,
      ST_NEW0   = 4'd1,
      ST_NEW1   = 4'd2,
      ST_NEW2   = 4'd3,
      ST_CFM0   = 4'd4,
      ST_CFM1   = 4'd5,
      ST_CFM2   = 4'd6,
      ST_COMMIT = 4'd7,
      ST_FAIL   = 4'd8
   } prog_state_t;

   // Entry states accept switch input and can be aborted or time out.
   function automatic logic is_entry(input prog_state_t s);
      return s inside {ST_NEW0, ST_NEW1, ST_NEW2, ST_CFM0, ST_CFM1, ST_CFM2};
   endfunction

endpackage

// File: rtl/idle_timer.sv
// rtl/idle_timer.sv - saturating idle counter; flags the last cycle before TIMEOUT
module idle_timer #(
   parameter int TIMEOUT = 1000000
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic count_en,
   output logic expired
);

   localparam int            CW   = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);
   localparam logic [CW-1:0] TOP  = CW'(TIMEOUT);

   logic [CW-1:0] count;

   // Holds at TOP rather than wrapping so a stale count can never look fresh.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (count_en && (count != TOP)) begin
         count <= count + CW'(1);
      end
   end

   assign expired = (count == LAST);

endmodule

// File: rtl/pwd_programmer.sv
// rtl/pwd_programmer.sv - two-pass password entry with atomic commit to the lock's compare registers
module pwd_programmer
   import lock_pkg::*;
#(
   parameter int              TIMEOUT     = 1000000,
   parameter logic [PW_W-1:0] DEFAULT_PWD = '0
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            prog_en,
   input  logic            enter_pulse,
   input  logic            cancel_pulse,
   input  logic [PW_W-1:0] sw,
   output logic [PW_W-1:0] pwd1,
   output logic [PW_W-1:0] pwd2,
   output logic [PW_W-1:0] pwd3,
   output logic            pwd_update,
   output logic            prog_err,
   output logic            busy,
   output logic [3:0]      stage
);

   prog_state_t     state;
   prog_state_t     state_next;
   logic [PW_W-1:0] stg [NUM_SEG];
   logic [PW_W-1:0] cur_stg;
   logic            mismatch;
   logic            in_entry;
   logic            abort;
   logic            take;
   logic            timer_clear;
   logic            timer_expired;

   assign in_entry = is_entry(state);
   assign abort    = cancel_pulse || !prog_en;
   assign take     = in_entry && enter_pulse && !abort;

   always_comb begin
      cur_stg = stg[0];
      case (state)
         ST_CFM1: cur_stg = stg[1];
         ST_CFM2: cur_stg = stg[2];
         default: cur_stg = stg[0];
      endcase
   end

   idle_timer #(
      .TIMEOUT (TIMEOUT)
   ) u_idle_timer (
      .clk      (clk),
      .rst      (rst),
      .clear    (timer_clear),
      .count_en (in_entry),
      .expired  (timer_expired)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next  = state;
      timer_clear = 1'b0;
      case (state)
         ST_IDLE: begin
            if (prog_en && enter_pulse) begin
               state_next  = ST_NEW0;
               timer_clear = 1'b1;
            end
         end
         ST_NEW0, ST_NEW1, ST_NEW2, ST_CFM0, ST_CFM1, ST_CFM2: begin
            if (abort) begin
               state_next = ST_IDLE;
            end else if (enter_pulse) begin
               timer_clear = 1'b1;
               case (state)
                  ST_NEW0: state_next = ST_NEW1;
                  ST_NEW1: state_next = ST_NEW2;
                  ST_NEW2: state_next = ST_CFM0;
                  ST_CFM0: state_next = ST_CFM1;
                  ST_CFM1: state_next = ST_CFM2;
                  // Verdict covers all three segments at once so no single one is revealed.
                  ST_CFM2: state_next = (mismatch || (sw != cur_stg)) ? ST_FAIL : ST_COMMIT;
                  default: state_next = ST_IDLE;
               endcase
            end else if (timer_expired) begin
               state_next = ST_FAIL;
            end
         end
         ST_COMMIT, ST_FAIL: state_next = ST_IDLE;
         default:            state_next = ST_IDLE;
      endcase
   end

   // Staging survives an abort; only a new pass overwrites it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NUM_SEG; i++) begin
            stg[i] <= '0;
         end
         mismatch <= 1'b0;
      end else if (take) begin
         case (state)
            ST_NEW0: stg[0] <= sw;
            ST_NEW1: stg[1] <= sw;
            ST_NEW2: begin
               stg[2]   <= sw;
               mismatch <= 1'b0;
            end
            default: begin
               if (sw != cur_stg) begin
                  mismatch <= 1'b1;
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pwd1 <= DEFAULT_PWD;
         pwd2 <= DEFAULT_PWD;
         pwd3 <= DEFAULT_PWD;
      end else if (state == ST_COMMIT) begin
         pwd1 <= stg[0];
         pwd2 <= stg[1];
         pwd3 <= stg[2];
      end
   end

   assign pwd_update = (state == ST_COMMIT);
   assign prog_err   = (state == ST_FAIL);
   assign busy       = (state != ST_IDLE);
   assign stage      = state;

endmodule
